// File: rtl/jump_sequencer_if.sv
// Fetch and decode handshake bundle between the PC sequencer,
// instruction memory port and decoder.
interface jump_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ack;
  logic                  instr_ready;
  logic                  instr_valid;
  logic                  jump_en;
  logic [3:0]            cond;
  logic [ADDR_WIDTH-1:0] target;
  logic                  call_en;
  logic                  ret_en;

  modport master (
    output fetch_req,
    output fetch_addr,
    output instr_ready,
    input  fetch_ack,
    input  instr_valid,
    input  jump_en,
    input  cond,
    input  target,
    input  call_en,
    input  ret_en
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  instr_ready,
    output fetch_ack,
    output instr_valid,
    output jump_en,
    output cond,
    output target,
    output call_en,
    output ret_en
  );
endinterface

// File: rtl/jump_sequencer.sv
// PC sequencer: flags, jump conditions, fetch/exec FSM.
// Define CALL_STACK_EN to build the call/return stack.
module jump_sequencer #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STACK_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flags_we,
  input  logic                  zero_in,
  input  logic                  carry_in,
  input  logic                  sign_in,
  input  logic                  overflow_in,
  jump_sequencer_if.master      bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  flush,
  output logic                  jump_taken,
  output logic                  stack_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [3:0]            flags_q;
  logic                  taken_q, taken_d;
  logic                  cond_ok;
  logic                  z, c, s, o;

  assign {z, c, s, o} = flags_q;
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ?
                         $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]       sp_q, sp_d;
  logic [IDX_W-1:0]      push_idx, pop_idx;
  logic                  err_q, err_d;
  logic                  push, full, empty;

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
  assign stack_err = err_q;
`else
  logic [STACK_DEPTH-1:0] unused_stack;
  logic                   unused_req;

  assign unused_stack = '0;
  assign unused_req   = bus.call_en ^ bus.ret_en;
  assign stack_err    = 1'b0;
`endif

  always_comb begin
    cond_ok = 1'b0;
    unique case (bus.cond)
      4'd0:    cond_ok = 1'b1;
      4'd1:    cond_ok = z;
      4'd2:    cond_ok = c;
      4'd3:    cond_ok = c | z;
      4'd4:    cond_ok = ~c & ~z;
      4'd5:    cond_ok = ~c;
      4'd6:    cond_ok = ~z & (s == o);
      4'd7:    cond_ok = (s == o);
      4'd8:    cond_ok = (s != o);
      4'd9:    cond_ok = z | (s != o);
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
`ifdef CALL_STACK_EN
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.fetch_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (bus.instr_valid) begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
`ifdef CALL_STACK_EN
          // Return outranks call, call outranks jump.
          if (bus.ret_en) begin
            if (empty) begin
              err_d = 1'b1;
            end else begin
              pc_d    = stack_q[pop_idx];
              sp_d    = sp_q - SP_W'(1);
              taken_d = 1'b1;
            end
          end else if (bus.call_en) begin
            pc_d    = bus.target;
            taken_d = 1'b1;
            if (full) begin
              err_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
            end
          end else
`endif
          if (bus.jump_en && cond_ok) begin
            pc_d    = bus.target;
            taken_d = 1'b1;
          end
          if (taken_d) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      flags_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      if (flags_we) begin
        flags_q <= {zero_in, carry_in,
                    sign_in, overflow_in};
      end
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entries above sp are never read, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end
`endif

  assign bus.fetch_req   = (state_q == S_FETCH);
  assign bus.fetch_addr  = pc_q;
  assign bus.instr_ready = (state_q == S_EXEC);
  assign pc              = pc_q;
  assign flush           = (state_q == S_FLUSH);
  assign jump_taken      = taken_q;

endmodule
